// File: rtl/seven_segment_pkg.sv
// Shared definitions for the 7-segment scan capture block.
//   SEG_DECODE     : active-high gfedcba pattern for each hex digit 0..F
//   seg_to_nibble  : pattern -> {match, nibble}; nibble is 0 when nothing matches
//   capture_state_t: per-dwell capture FSM states
package seven_segment_pkg;

  localparam logic [6:0] SEG_DECODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } capture_state_t;

  // Table entries are unique, so at most one iteration can match.
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
    logic [4:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_DECODE[i]) begin
        res = {1'b1, 4'(i)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_capture_if.sv
// Multiplexed 7-segment scan bus (active-low anodes and cathodes).
//   anode   : one bit per digit, low = digit selected
//   cathode : bit0=A .. bit6=G, bit7=dot, low = segment lit
// master drives the bus (display driver), slave observes it (capture).
interface seven_segment_capture_if #(
  parameter int unsigned NUM_SEGMENTS = 4
) ();

  logic [NUM_SEGMENTS-1:0] anode;
  logic [7:0]              cathode;

  modport master (output anode, output cathode);
  modport slave  (input  anode, input  cathode);

endinterface

// File: rtl/seven_segment_scan_classify.sv
// Combinational classification of an active-low anode scan word.
//   anode : scan anodes, active-low
//   blank : all anodes high (no digit selected)
//   legal : exactly one anode low
//   index : position of the low anode when legal (don't-care otherwise)
module seven_segment_scan_classify #(
  parameter int unsigned NUM_SEGMENTS = 4,
  localparam int unsigned IdxW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic [NUM_SEGMENTS-1:0] anode,
  output logic                    blank,
  output logic                    legal,
  output logic [IdxW-1:0]         index
);

  int unsigned zero_cnt;

  always_comb begin
    zero_cnt = 0;
    index    = '0;
    for (int unsigned i = 0; i < NUM_SEGMENTS; i++) begin
      if (!anode[i]) begin
        zero_cnt = zero_cnt + 1;
        index    = IdxW'(i);
      end
    end
  end

  assign blank = &anode;
  assign legal = (zero_cnt == 1);

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of the multiplexed 7-segment driver: waits for each digit's
// dwell to settle, decodes the cathode pattern and assembles a full frame.
//   clk, CPU_RESETN : clock, asynchronous active-low reset
//   scan            : anode/cathode scan bus (slave side)
//   encoded         : last complete frame, one nibble per digit (index = anode bit)
//   digit_point     : decimal point per digit of the last frame (1 = lit)
//   seg_err         : 1 = cathode pattern of that digit not a hex glyph
//   frame_valid     : one-cycle pulse when the three frame outputs update
//   anode_err       : one-cycle pulse on the first cycle of an illegal anode pattern
//   stale           : level, no frame completed for STALE_CYCLES cycles
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_SEGMENTS  = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STALE_CYCLES  = 400000
) (
  input  logic                         clk,
  input  logic                         CPU_RESETN,
  seven_segment_capture_if.slave       scan,
  output logic [NUM_SEGMENTS-1:0][3:0] encoded,
  output logic [NUM_SEGMENTS-1:0]      digit_point,
  output logic [NUM_SEGMENTS-1:0]      seg_err,
  output logic                         frame_valid,
  output logic                         anode_err,
  output logic                         stale
);

  localparam int unsigned IdxW    = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned StaleW  = $clog2(STALE_CYCLES + 1);

  // Input register plus one-cycle history for change detection.
  logic [NUM_SEGMENTS-1:0] anode_q, anode_p;
  logic [7:0]              cathode_q, cathode_p;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      anode_q   <= '1;
      anode_p   <= '1;
      cathode_q <= '1;
      cathode_p <= '1;
    end else begin
      anode_q   <= scan.anode;
      cathode_q <= scan.cathode;
      anode_p   <= anode_q;
      cathode_p <= cathode_q;
    end
  end

  logic            anode_blank, anode_legal;
  logic [IdxW-1:0] anode_idx;

  seven_segment_scan_classify #(
    .NUM_SEGMENTS (NUM_SEGMENTS)
  ) u_classify (
    .anode (anode_q),
    .blank (anode_blank),
    .legal (anode_legal),
    .index (anode_idx)
  );

  logic anode_chg, scan_chg;
  assign anode_chg = (anode_q != anode_p);
  assign scan_chg  = anode_chg || (cathode_q != cathode_p);
  // A new illegal pattern differs from the previous word, so this is an edge.
  assign anode_err = !anode_blank && !anode_legal && anode_chg;

  // Capture FSM
  capture_state_t     state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic               capture;

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (anode_legal) begin
          state_d      = SETTLE;
          settle_cnt_d = SettleW'(1);
        end
      end
      SETTLE: begin
        if (!anode_legal) begin
          state_d      = IDLE;
          settle_cnt_d = '0;
        end else if (scan_chg) begin
          // Any change restarts the dwell, even on the would-be capture cycle.
          settle_cnt_d = SettleW'(1);
        end else if (32'(settle_cnt_q) + 32'd1 >= SETTLE_CYCLES) begin
          capture      = 1'b1;
          state_d      = HOLD;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleW'(1);
        end
      end
      HOLD: begin
        // Only an anode change ends the dwell; cathode flicker is ignored.
        if (anode_chg) begin
          if (anode_legal) begin
            state_d      = SETTLE;
            settle_cnt_d = SettleW'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  // Staging, frame assembly and stale tracking
  logic [4:0] seg_dec;
  assign seg_dec = seg_to_nibble(~cathode_q[6:0]);

  logic [NUM_SEGMENTS-1:0][3:0] stage_nib_q, stage_nib_d, encoded_q, encoded_d;
  logic [NUM_SEGMENTS-1:0]      stage_dp_q, stage_dp_d, stage_err_q, stage_err_d;
  logic [NUM_SEGMENTS-1:0]      mask_q, mask_d;
  logic [NUM_SEGMENTS-1:0]      dp_q, dp_d, err_q, err_d;
  logic                         frame_valid_q, frame_done;
  logic [StaleW-1:0]            stale_cnt_q, stale_cnt_d;

  assign frame_done = &mask_q;

  always_comb begin
    stage_nib_d = stage_nib_q;
    stage_dp_d  = stage_dp_q;
    stage_err_d = stage_err_q;
    mask_d      = frame_done ? '0 : mask_q;
    encoded_d   = frame_done ? stage_nib_q : encoded_q;
    dp_d        = frame_done ? stage_dp_q  : dp_q;
    err_d       = frame_done ? stage_err_q : err_q;
    if (capture) begin
      stage_nib_d[anode_idx] = seg_dec[3:0];
      stage_dp_d[anode_idx]  = ~cathode_q[7];
      stage_err_d[anode_idx] = ~seg_dec[4];
      mask_d[anode_idx]      = 1'b1;
    end
    // Clearing on frame_done (not on the pulse) lets stale drop with frame_valid.
    if (frame_done) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q != StaleW'(STALE_CYCLES)) begin
      stale_cnt_d = stale_cnt_q + StaleW'(1);
    end else begin
      stale_cnt_d = stale_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      stage_nib_q   <= '0;
      stage_dp_q    <= '0;
      stage_err_q   <= '0;
      mask_q        <= '0;
      encoded_q     <= '0;
      dp_q          <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      stale_cnt_q   <= '0;
    end else begin
      stage_nib_q   <= stage_nib_d;
      stage_dp_q    <= stage_dp_d;
      stage_err_q   <= stage_err_d;
      mask_q        <= mask_d;
      encoded_q     <= encoded_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      frame_valid_q <= frame_done;
      stale_cnt_q   <= stale_cnt_d;
    end
  end

  assign encoded     = encoded_q;
  assign digit_point = dp_q;
  assign seg_err     = err_q;
  assign frame_valid = frame_valid_q;
  assign stale       = (stale_cnt_q == StaleW'(STALE_CYCLES));

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: table of full frames plus
// hand-written sequences for settle boundary, illegal anodes, stale and reset.
module tb_seven_segment_capture;

  localparam int unsigned NSeg   = 4;
  localparam int unsigned Settle = 16;
  localparam int unsigned Stale  = 200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_segment_capture_if #(.NUM_SEGMENTS(NSeg)) scan_if ();

  logic [NSeg-1:0][3:0] encoded;
  logic [NSeg-1:0]      digit_point, seg_err;
  logic                 frame_valid, anode_err, stale;

  seven_segment_capture #(
    .NUM_SEGMENTS  (NSeg),
    .SETTLE_CYCLES (Settle),
    .STALE_CYCLES  (Stale)
  ) dut (
    .clk         (clk),
    .CPU_RESETN  (rst_n),
    .scan        (scan_if),
    .encoded     (encoded),
    .digit_point (digit_point),
    .seg_err     (seg_err),
    .frame_valid (frame_valid),
    .anode_err   (anode_err),
    .stale       (stale)
  );

  // Event monitor, sampled away from the active edge.
  int unsigned cyc = 0, fv_cnt = 0, err_cnt = 0, fv_cyc = 0, rise_cyc = 0;
  logic stale_prev = 1'b0, stale_pre_fv = 1'b0, stale_at_fv = 1'b0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    stale_prev <= stale;
    if (frame_valid) begin
      fv_cnt       <= fv_cnt + 1;
      fv_cyc       <= cyc;
      stale_at_fv  <= stale;
      stale_pre_fv <= stale_prev;
    end
    if (anode_err) err_cnt <= err_cnt + 1;
    if (stale && !stale_prev) rise_cyc <= cyc;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] cat, input int n);
    scan_if.anode   = an;
    scan_if.cathode = cat;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int k, input logic [7:0] cat, input int n);
    logic [3:0] sel;
    sel = 4'b0001 << k;
    drive(~sel, cat, n);
  endtask

  task automatic run_frame(input logic [3:0][7:0] cats);
    for (int k = 0; k < 4; k++) digit(k, cats[k], 100);
  endtask

  typedef struct {
    logic [3:0][7:0] cat;   // cathode per digit, [0] = digit 0
    logic [15:0]     enc;   // digit3..digit0
    logic [3:0]      dp;
    logic [3:0]      err;
  } frame_vec_t;

  frame_vec_t  vecs [5];
  int unsigned fv_base, err_base;
  int          waited;

  initial begin
    vecs[0] = '{cat: {8'h08, 8'hA4, 8'hF9, 8'hC0}, enc: 16'hA210, dp: 4'b1000, err: 4'b0000};
    vecs[1] = '{cat: {8'h92, 8'hFF, 8'h99, 8'hB0}, enc: 16'h5043, dp: 4'b0000, err: 4'b0100};
    vecs[2] = '{cat: {8'h90, 8'h86, 8'h8E, 8'h03}, enc: 16'h9EFB, dp: 4'b0001, err: 4'b0000};
    vecs[3] = '{cat: {8'h00, 8'hA1, 8'hFE, 8'hC6}, enc: 16'h8D0C, dp: 4'b1000, err: 4'b0010};
    vecs[4] = '{cat: {8'h90, 8'h80, 8'hF8, 8'h82}, enc: 16'h9876, dp: 4'b0000, err: 4'b0000};

    // Reset values
    rst_n = 1'b0;
    scan_if.anode   = 4'hF;
    scan_if.cathode = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_encoded", encoded, 0);
    check("rst_digit_point", digit_point, 0);
    check("rst_seg_err", seg_err, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_anode_err", anode_err, 0);
    check("rst_stale", stale, 0);
    rst_n = 1'b1;
    drive(4'hF, 8'hFF, 5);

    // Table of full frames, 100-cycle dwell per digit
    for (int i = 0; i < 5; i++) begin
      fv_base = fv_cnt;
      run_frame(vecs[i].cat);
      drive(4'hF, 8'hFF, 4);
      check($sformatf("rec%0d_frame_pulses", i), fv_cnt - fv_base, 1);
      check($sformatf("rec%0d_encoded", i), encoded, vecs[i].enc);
      check($sformatf("rec%0d_digit_point", i), digit_point, vecs[i].dp);
      check($sformatf("rec%0d_seg_err", i), seg_err, vecs[i].err);
    end

    // Short dwell on digit 0, then the settle boundary (15 fails, 16 captures)
    fv_base = fv_cnt;
    digit(0, 8'hC0, 10);
    digit(1, 8'hF9, 100);
    digit(2, 8'hA4, 100);
    digit(3, 8'h08, 100);
    drive(4'hF, 8'hFF, 4);
    check("short_dwell_no_frame", fv_cnt - fv_base, 0);
    digit(0, 8'hC0, 15);
    drive(4'hF, 8'hFF, 20);
    check("dwell15_no_frame", fv_cnt - fv_base, 0);
    digit(0, 8'hC0, 16);
    drive(4'hF, 8'hFF, 20);
    check("dwell16_frame", fv_cnt - fv_base, 1);
    check("dwell16_encoded", encoded, 16'hA210);

    // Illegal anode patterns: one pulse per new pattern, never a capture
    fv_base  = fv_cnt;
    err_base = err_cnt;
    drive(4'b1100, 8'hC0, 5);
    drive(4'hF, 8'hFF, 3);
    check("illegal_one_pulse", err_cnt - err_base, 1);
    drive(4'b1100, 8'hC0, 3);
    drive(4'b1010, 8'hC0, 3);
    drive(4'hF, 8'hFF, 3);
    check("illegal_two_patterns", err_cnt - err_base, 3);
    check("illegal_no_frame", fv_cnt - fv_base, 0);

    // Scan halted: stale exactly STALE_CYCLES after the last frame_valid
    waited = 0;
    while (!stale && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("stale_asserts", stale, 1);
    check("stale_delay", rise_cyc - fv_cyc, Stale);

    // Next frame drops stale on the frame_valid cycle
    fv_base = fv_cnt;
    run_frame(vecs[0].cat);
    drive(4'hF, 8'hFF, 4);
    check("stale_frame_pulses", fv_cnt - fv_base, 1);
    check("stale_before_fv", stale_pre_fv, 1);
    check("stale_at_fv", stale_at_fv, 0);
    check("stale_after_fv", stale, 0);

    // Reset mid-settle with three digits staged
    digit(0, 8'hC0, 100);
    digit(1, 8'hF9, 100);
    digit(2, 8'hA4, 100);
    digit(3, 8'h08, 5);
    rst_n = 1'b0;
    #1;
    check("midrst_encoded", encoded, 0);
    check("midrst_digit_point", digit_point, 0);
    check("midrst_seg_err", seg_err, 0);
    check("midrst_frame_valid", frame_valid, 0);
    check("midrst_stale", stale, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fv_base = fv_cnt;
    digit(3, 8'h08, 100);
    digit(0, 8'hC0, 100);
    digit(1, 8'hF9, 100);
    check("midrst_needs_fresh", fv_cnt - fv_base, 0);
    digit(2, 8'hA4, 100);
    drive(4'hF, 8'hFF, 4);
    check("midrst_frame", fv_cnt - fv_base, 1);
    check("midrst_encoded_after", encoded, 16'hA210);
    check("midrst_dp_after", digit_point, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver.
- Samples the active-low anode/cathode scan bus and waits for each digit's dwell to settle.
- Decodes each cathode pattern back to a hex nibble plus decimal point, and assembles a full frame of NUM_SEGMENTS digits.
- Used for on-board loopback self-check and as a bench monitor behind the counter/display top levels.

Parameters:
- NUM_SEGMENTS, 4, digits per display; anode width and frame size.
- SETTLE_CYCLES, 16, cycles the anode and cathode must be stable before a digit is captured; range 1..255.
- STALE_CYCLES, 400000, cycles without a completed frame before `stale` is asserted (4 ms at CLK_PER=10, REFR_RATE=1000).

Ports:
- clk  input  1  system clock; single clock domain.
- CPU_RESETN  input  1  asynchronous active-low reset.
- anode  input  NUM_SEGMENTS  scan anodes, active-low, same clock domain as the driver.
- cathode  input  8  segments, active-low; bit0=A … bit6=G, bit7=dot.
- encoded  output  NUM_SEGMENTS x 4  last complete frame, one nibble per digit; index = anode bit.
- digit_point  output  NUM_SEGMENTS  decimal point per digit of the last frame (1 = lit).
- seg_err  output  NUM_SEGMENTS  per digit of the last frame: 1 = cathode pattern not in the hex table.
- frame_valid  output  1  one-cycle pulse when encoded/digit_point/seg_err update.
- anode_err  output  1  one-cycle pulse when an illegal anode pattern is registered.
- stale  output  1  level; scan has stopped delivering frames.

Behaviour:
- **Reset (CPU_RESETN low, asynchronous):**
  - encoded=0, digit_point=0, seg_err=0, frame_valid=0, anode_err=0, stale=0.
  - FSM=IDLE; settle and stale counters, staging registers and capture mask all cleared.
  - Deassertion is used as-is; upstream provides a cleaned release.
- **Input register:** anode and cathode are registered once (1 cycle) before use. All descriptions below refer to the registered values.
- **Anode classification:**
  - all ones = blank;
  - exactly one zero at index k = select k;
  - anything else = illegal.
  - Illegal: anode_err pulses on the first cycle of each illegal pattern (edge, not level); FSM goes to IDLE.
- **FSM states:**
  - IDLE: anode blank or illegal. A legal select moves to SETTLE with settle count = 1.
  - SETTLE: if anode or cathode differs from the previous cycle, the count restarts at 1 (anode change to blank/illegal goes to IDLE). Otherwise the count increments. When the count reaches SETTLE_CYCLES, capture digit k and go to HOLD. A change on the same cycle the count would complete wins: no capture.
  - HOLD: one capture per dwell. Stay in HOLD until anode changes; then go to SETTLE (new legal select) or IDLE. Cathode changes within HOLD are ignored.
- **Capture of digit k:**
  - Decode ~cathode[6:0] through the hex table.
  - Stage nibble[k], dp[k] = ~cathode[7], err[k] = no table match (nibble = 0 on mismatch, blank included).
  - Set mask[k]. A re-capture of k before frame completion overwrites the staged values; the mask is unchanged.
- **Frame completion:**
  - The cycle after the mask becomes all ones: encoded/digit_point/seg_err are loaded from staging, frame_valid pulses, and the mask clears.
  - Latency from final capture to frame_valid is 1 cycle.
  - Worst case from anode select to frame_valid = 1 (input reg) + SETTLE_CYCLES + 1.
- **Stale counter:**
  - Clears on frame_valid; otherwise increments, saturating at STALE_CYCLES.
  - stale = (count == STALE_CYCLES). stale drops the cycle frame_valid pulses.
- **Widths:** settle counter $clog2(SETTLE_CYCLES+1) bits; stale counter $clog2(STALE_CYCLES+1) bits. Neither counter wraps.

Decomposition:
- **Package seven_segment_pkg:**
  - SEG_DECODE table, active-high gfedcba → nibble: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - Function seg_to_nibble returning {match, nibble}.
  - capture_state_t enum {IDLE, SETTLE, HOLD}.
- **Sub-module seven_segment_scan_classify:** combinational anode → {blank, legal, index}; reused by the top-level loopback checker.

Test Plan:
- Reset → encoded=0, digit_point=0, seg_err=0, frame_valid=0, anode_err=0, stale=0.
- Drive 4 digits, each dwell 100 cycles: anode 1110/cathode C0, 1101/F9, 1011/A4, 0111/08 (dot on) → frame_valid pulse; encoded={A,2,1,0} (digit3..0); digit_point=1000; seg_err=0000.
- Anode 1110 held 10 cycles (< SETTLE_CYCLES=16), then switched to 1101 → digit 0 not captured; no frame_valid until digit 0 dwells ≥16 stable cycles.
- Digit 2 cathode = 0xFF (blank) within a full frame → seg_err=0100, encoded[2]=0; anode 1100 for 5 cycles → exactly one anode_err pulse, no capture.
- Scan halted at anode 1111 → stale asserts after STALE_CYCLES (scaled to 200 in the bench); next full frame → stale deasserts on the frame_valid cycle.
- CPU_RESETN asserted mid-SETTLE after 3 digits staged → outputs cleared immediately; after release, the next frame requires all 4 fresh captures.
